uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Byte scheduler that shares the single UART transmitter between two byte requesters: the button-triggered frame source (req0) and the switch-change reporter (req1). It accepts one byte at a time over a valid/ready handshake, chooses between the requesters, and pulses the transmitter's start strobe. It then tracks the transmitter's busy flag and enforces a programmable idle gap between bytes. It sits between the request sources and the UART transmitter in the top level, and drives `rts`.

## Interface
- `DATA_W`, 8: byte width.
- `GAP_CYCLES`, 16: idle clocks inserted after each byte completes; 0 means no gap.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a byte.
- `req0_data` in DATA_W: requester 0 byte.
- `req0_ready` out 1: requester 0 byte accepted this cycle.
- `req1_valid` in 1: requester 1 has a byte.
- `req1_data` in DATA_W: requester 1 byte.
- `req1_ready` out 1: requester 1 byte accepted this cycle.
- `tx_busy` in 1: UART transmitter is shifting a frame.
- `tx_start` out 1: one-cycle start strobe to the transmitter.
- `tx_data` out DATA_W: byte presented to the transmitter, held stable from the START state through the end of WAIT_DONE.
- `rts` out 1: high while a byte is in flight (START, WAIT_BUSY, WAIT_DONE).
- `grant_id` out 1: index of the requester that owns the current or last byte.

## Operation
- The FSM has five states: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE**
  - If any `reqN_valid` is high, select a winner and drive its `reqN_ready`=1 combinationally in the same cycle.
  - Latch `reqN_data` into `tx_data`, set `grant_id`, and go to START.
  - If no request is valid, both ready outputs stay 0.
- **START**: `tx_start`=1 for exactly one cycle; go to WAIT_BUSY.
- **WAIT_BUSY**: wait for `tx_busy`=1, then go to WAIT_DONE.
- **WAIT_DONE**: wait for `tx_busy`=0.
  - If `GAP_CYCLES`>0, load the gap counter with `GAP_CYCLES`-1 and go to GAP.
  - Otherwise go to IDLE.
- **GAP**: decrement the counter each cycle; when it reaches 0, go to IDLE.
- Ready outputs are 0 in every state other than IDLE. A requester must hold valid and data stable until it sees ready.
- The gap counter width is clog2(`GAP_CYCLES`+1). The counter never wraps: it saturates at 0.
- Arbitration with both requesters valid in IDLE follows the Configuration section.
- A requester that drops valid before it is granted is never granted.

## Timing
- **Reset values**: state IDLE, `tx_start`=0, `tx_data`=0, `rts`=0, `grant_id`=0, both ready outputs 0, last-grant register=1 (so req0 wins first), gap counter=0.
- **Latency**: valid accepted in cycle n (IDLE) → `tx_start` high in cycle n+1 → `rts` high from n+1.
- **Minimum byte-to-byte spacing**: transmitter frame time + `GAP_CYCLES` + 2 clocks.
- **`tx_busy` already high in START**: the FSM still passes through WAIT_BUSY and advances on the next cycle.
- **`rts` timing**: `rts` falls on the clock after `tx_busy` is sampled low.
- **Reset mid-operation**: all registers return to their reset values immediately, with no held-over grant. A byte that was accepted but not yet sent is discarded.
- `tx_data` does not change while `rts`=1.

## Configuration
- Macro: `UART_TX_SCHED_RR_EN`.
- **Defined**: round-robin arbitration.
  - On a tie, grant the requester that was not granted last.
  - The last-grant register updates on each IDLE acceptance.
- **Undefined**: fixed priority, req0 always wins a tie.
  - The last-grant register is not implemented.
  - req1 can starve if req0 is continuously valid.

## Structure
- **Shared package `uart_pkg`**:
  - FSM state enumeration: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
  - `DATA_W` default constant.
  - Requester index constants `REQ_BTN`=0 and `REQ_SW`=1.
- **Sub-module `tx_gap_timer`**:
  - Loadable down-counter with a `done` flag, parameterised by `GAP_CYCLES`.
  - Reused later for the receiver timeout.
- The arbiter and FSM stay in `uart_tx_sched`.

## Test plan
- **Reset**: `rst` pulsed for 10 clocks, requests idle → `tx_start`=0, `rts`=0, `tx_data`=0, ready outputs 0. Assert `rst` while in WAIT_DONE → the FSM is back in IDLE on the next clock and `rts`=0.
- **Single byte**: req0 sends 0xA5, transmitter model drives busy for 20 clocks → `req0_ready` for 1 cycle, `tx_start` 1 cycle later with `tx_data`=0xA5, `rts` high for 22 cycles, next acceptance no earlier than 16 clocks after busy falls.
- **Tie with RR**: `UART_TX_SCHED_RR_EN` defined, both requesters valid continuously (req0 0x11, req1 0x22) → send order 0x11, 0x22, 0x11, 0x22, with `grant_id` alternating 0,1,0,1.
- **Tie without RR**: macro undefined, same stimulus → four sends of 0x11, `req1_ready` never asserted.
- **Zero gap**: `GAP_CYCLES`=0, two req1 bytes 0x01 and 0x02 → second `req1_ready` in the cycle after busy falls, second `tx_start` one cycle later.
- **Early busy**: transmitter model raises busy in the same cycle as `tx_start` and holds it 5 clocks → exactly one `tx_start` pulse and a correct return to IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-scheduler FSM states, default byte width
// and requester indices.
package uart_pkg;

  localparam int DATA_W_DFLT = 8;

  localparam logic REQ_BTN = 1'b0;
  localparam logic REQ_SW  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } tx_state_e;

endpackage

// File: rtl/tx_gap_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
// Loads GAP_CYCLES-1 so that a wait covers exactly GAP_CYCLES clocks.
module tx_gap_timer #(
  parameter int GAP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between two byte requesters, with an idle gap per byte.
// Define UART_TX_SCHED_RR_EN for round-robin ties; otherwise req0 has fixed priority.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              rts,
  output logic              grant_id
);

  tx_state_e state;
  logic      grant_sel;
  logic      accept;
  logic      gap_load;
  logic      gap_done;

`ifdef UART_TX_SCHED_RR_EN
  logic last_grant;

  // Reset value 1 makes req0 the winner of the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_sel;
    end
  end

  always_comb begin
    grant_sel = REQ_BTN;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant;
    end else if (req1_valid) begin
      grant_sel = REQ_SW;
    end
  end
`else
  assign grant_sel = req0_valid ? REQ_BTN : REQ_SW;
`endif

  // Ready is suppressed during reset so no byte is taken that would be discarded.
  assign accept     = (state == ST_IDLE) && (req0_valid || req1_valid) && !rst;
  assign req0_ready = accept && (grant_sel == REQ_BTN);
  assign req1_ready = accept && (grant_sel == REQ_SW);

  assign tx_start = (state == ST_START);
  assign rts      = (state == ST_START) || (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
  assign gap_load = (state == ST_WAIT_DONE) && !tx_busy && (GAP_CYCLES > 0);

  tx_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap (
    .clk (clk),
    .rst (rst),
    .load(gap_load),
    .done(gap_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (accept) state <= ST_START;
        ST_START:     state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (tx_busy) state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!tx_busy) state <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        ST_GAP:       if (gap_done) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  // Byte and owner are captured only on acceptance, so they stay put while rts is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data  <= '0;
      grant_id <= 1'b0;
    end else if (accept) begin
      tx_data  <= (grant_sel == REQ_SW) ? req1_data : req0_data;
      grant_id <= grant_sel;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Checks uart_tx_sched (gap 16 and gap 0 instances) against an event-level model
// of the scheduling rules, with directed scenarios followed by random traffic.
module tb_uart_tx_sched;

  logic clk = 1'b0;
  logic rst;
  logic v0 [2], v1 [2], r0 [2], r1 [2], bsy [2], ts [2], rt [2], gi [2];
  logic [7:0] d0 [2], d1 [2], td [2];

  int n_run = 0;
  int n_fail = 0;
  int k = 0;
  bit rr_mode;
  bit rst_cmd;
  bit rnd = 1'b0;

  // requester and transmitter environment
  bit         pend [2][2];
  logic [7:0] pdat [2][2];
  int         cont [2][2];
  logic [7:0] nxt  [2][2];
  int brem [2];
  int blen [2];
  bit early [2];

  // reference model of the scheduling rules
  bit         fl [2];
  int         s [2];
  bit         seen [2];
  int         free_at [2];
  bit         lg [2];
  logic [7:0] ed [2];
  bit         eg [2];

  // send log
  logic [7:0] sdat [2][16];
  bit         sgid [2][16];
  int         scyc [2][16];
  int ns [2], rts_cnt [2], ts_cnt [2], r1_cnt [2];

  always #5 clk = ~clk;

  uart_tx_sched #(.DATA_W(8), .GAP_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(r0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(r1[0]),
    .tx_busy(bsy[0]), .tx_start(ts[0]), .tx_data(td[0]), .rts(rt[0]), .grant_id(gi[0])
  );

  uart_tx_sched #(.DATA_W(8), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(r0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(r1[1]),
    .tx_busy(bsy[1]), .tx_start(ts[1]), .tx_data(td[1]), .rts(rt[1]), .grant_id(gi[1])
  );

  function automatic int gap_of(input int i);
    return (i == 0) ? 16 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int i);
    int G;
    bit w, can, er0, er1, ets, erts;
    G = gap_of(i);
    if (rst) begin
      fl[i] = 1'b0; lg[i] = 1'b1; ed[i] = 8'h00; eg[i] = 1'b0; free_at[i] = k + 1;
    end
    can = !rst && !fl[i] && (k >= free_at[i]);
    if (v0[i] && v1[i]) w = rr_mode ? !lg[i] : 1'b0;
    else w = v1[i];
    er0  = can && v0[i] && !w;
    er1  = can && v1[i] && w;
    ets  = fl[i] && (k == s[i]);
    erts = fl[i] && (k >= s[i]);
    chk($sformatf("i%0d.req0_ready@%0d", i, k), 32'(r0[i]), 32'(er0));
    chk($sformatf("i%0d.req1_ready@%0d", i, k), 32'(r1[i]), 32'(er1));
    chk($sformatf("i%0d.tx_start@%0d", i, k), 32'(ts[i]), 32'(ets));
    chk($sformatf("i%0d.rts@%0d", i, k), 32'(rt[i]), 32'(erts));
    chk($sformatf("i%0d.tx_data@%0d", i, k), 32'(td[i]), 32'(ed[i]));
    chk($sformatf("i%0d.grant_id@%0d", i, k), 32'(gi[i]), 32'(eg[i]));
    if (ts[i] === 1'b1) begin
      if (ns[i] < 16) begin
        sdat[i][ns[i]] = td[i]; sgid[i][ns[i]] = gi[i]; scyc[i][ns[i]] = k;
      end
      ns[i]++; ts_cnt[i]++;
      if (rnd) begin
        early[i] = 1'($urandom_range(0, 1));
        blen[i]  = early[i] ? $urandom_range(2, 6) : $urandom_range(1, 6);
      end
      if (early[i]) begin
        bsy[i] = 1'b1; brem[i] = blen[i];
      end
    end
    if (rt[i] === 1'b1) rts_cnt[i]++;
    if (r1[i] === 1'b1) r1_cnt[i]++;
    for (int r = 0; r < 2; r++) begin
      if ((r == 0 && r0[i] === 1'b1) || (r == 1 && r1[i] === 1'b1)) begin
        if (cont[i][r] > 0) begin
          cont[i][r]--; pdat[i][r] = nxt[i][r];
        end else begin
          pend[i][r] = 1'b0;
        end
      end
    end
    if (!rst) begin
      if (er0 || er1) begin
        fl[i] = 1'b1; s[i] = k + 1; seen[i] = 1'b0;
        ed[i] = w ? d1[i] : d0[i]; eg[i] = w; lg[i] = w;
      end else if (fl[i] && k >= s[i] + 1) begin
        if (!seen[i]) begin
          if (bsy[i]) seen[i] = 1'b1;
        end else if (!bsy[i]) begin
          fl[i] = 1'b0; free_at[i] = k + 1 + G;
        end
      end
    end
    if (bsy[i] && brem[i] > 0) brem[i]--;
    if (ts[i] === 1'b1 && !early[i]) brem[i] = blen[i];
  endtask

  task automatic step();
    @(negedge clk);
    k++;
    rst = rst_cmd;
    for (int i = 0; i < 2; i++) begin
      if (rst) brem[i] = 0;
      for (int r = 0; r < 2; r++) begin
        if (rnd) begin
          if (pend[i][r] && $urandom_range(0, 15) == 0) pend[i][r] = 1'b0;
          else if (!pend[i][r] && $urandom_range(0, 3) == 0) begin
            pend[i][r] = 1'b1; pdat[i][r] = 8'($urandom);
          end
        end
      end
      v0[i] = pend[i][0]; d0[i] = pdat[i][0];
      v1[i] = pend[i][1]; d1[i] = pdat[i][1];
      bsy[i] = !rst && (brem[i] > 0);
    end
    #1;
    for (int i = 0; i < 2; i++) check_inst(i);
  endtask

  task automatic clear_log(input int i);
    ns[i] = 0; rts_cnt[i] = 0; ts_cnt[i] = 0; r1_cnt[i] = 0;
  endtask

  task automatic run_until_sent(input int i, input int n, input int budget);
    int b = 0;
    while (ns[i] < n && b < budget) begin
      step(); b++;
    end
    chk($sformatf("i%0d.sends_within_budget", i), 32'(ns[i]), 32'(n));
  endtask

  task automatic drain(input int i);
    int b = 0;
    while ((fl[i] || k < free_at[i]) && b < 600) begin
      step(); b++;
    end
    chk($sformatf("i%0d.rts_after_drain", i), 32'(rt[i]), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_d [4];
    bit         exp_g [4];
`ifdef UART_TX_SCHED_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 2; r++) begin
        pend[i][r] = 1'b0; pdat[i][r] = 8'h00; cont[i][r] = 0; nxt[i][r] = 8'h00;
      end
      brem[i] = 0; blen[i] = 4; early[i] = 1'b0;
      fl[i] = 1'b0; s[i] = 0; seen[i] = 1'b0; free_at[i] = 0; lg[i] = 1'b1;
      ed[i] = 8'h00; eg[i] = 1'b0;
      v0[i] = 1'b0; v1[i] = 1'b0; d0[i] = 8'h00; d1[i] = 8'h00; bsy[i] = 1'b0;
      clear_log(i);
    end
    rst_cmd = 1'b1;
    rst = 1'b1;

    // reset held for 10 clocks with requests idle
    repeat (10) step();
    chk("reset.tx_start", 32'(ts[0]), 32'd0);
    chk("reset.rts", 32'(rt[0]), 32'd0);
    chk("reset.tx_data", 32'(td[0]), 32'd0);
    rst_cmd = 1'b0;
    step();

    // single byte 0xA5 with a 20-clock frame, then 0x5A queued behind it
    clear_log(0);
    blen[0] = 20;
    pend[0][0] = 1'b1; pdat[0][0] = 8'hA5; cont[0][0] = 1; nxt[0][0] = 8'h5A;
    run_until_sent(0, 2, 200);
    drain(0);
    chk("single.data0", 32'(sdat[0][0]), 32'hA5);
    chk("single.gid0", 32'(sgid[0][0]), 32'd0);
    chk("single.data1", 32'(sdat[0][1]), 32'h5A);
    // 22 rts clocks (START, WAIT_BUSY, 20 in WAIT_DONE) + 16 gap + 1 idle acceptance
    chk("single.start_spacing", 32'(scyc[0][1] - scyc[0][0]), 32'd39);
    chk("single.rts_clocks", 32'(rts_cnt[0]), 32'd44);
    chk("single.start_pulses", 32'(ts_cnt[0]), 32'd2);

    // tie: both requesters continuously valid, fresh reset so req0 wins first
    rst_cmd = 1'b1; repeat (2) step(); rst_cmd = 1'b0;
    clear_log(0);
    blen[0] = 4;
    pend[0][0] = 1'b1; pdat[0][0] = 8'h11; cont[0][0] = 3; nxt[0][0] = 8'h11;
    pend[0][1] = 1'b1; pdat[0][1] = 8'h22; cont[0][1] = 3; nxt[0][1] = 8'h22;
    run_until_sent(0, 4, 400);
    if (rr_mode) begin
      exp_d = '{8'h11, 8'h22, 8'h11, 8'h22}; exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    end else begin
      exp_d = '{8'h11, 8'h11, 8'h11, 8'h11}; exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
    end
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("tie.data%0d", n), 32'(sdat[0][n]), 32'(exp_d[n]));
      chk($sformatf("tie.gid%0d", n), 32'(sgid[0][n]), 32'(exp_g[n]));
    end
    chk("tie.req1_ready_count", 32'(r1_cnt[0]), rr_mode ? 32'd2 : 32'd0);
    for (int r = 0; r < 2; r++) begin
      pend[0][r] = 1'b0; cont[0][r] = 0;
    end
    drain(0);

    // zero gap: two req1 bytes back to back on the GAP_CYCLES=0 instance
    clear_log(1);
    blen[1] = 3;
    pend[1][1] = 1'b1; pdat[1][1] = 8'h01; cont[1][1] = 1; nxt[1][1] = 8'h02;
    run_until_sent(1, 2, 100);
    chk("zgap.data0", 32'(sdat[1][0]), 32'h01);
    chk("zgap.data1", 32'(sdat[1][1]), 32'h02);
    chk("zgap.gid1", 32'(sgid[1][1]), 32'd1);
    // 5 rts clocks (START, WAIT_BUSY, 3 in WAIT_DONE) + 0 gap + 1 idle acceptance
    chk("zgap.start_spacing", 32'(scyc[1][1] - scyc[1][0]), 32'd6);
    drain(1);

    // early busy: transmitter raises busy in the tx_start cycle for 5 clocks
    clear_log(1);
    early[1] = 1'b1; blen[1] = 5;
    pend[1][0] = 1'b1; pdat[1][0] = 8'h3C;
    run_until_sent(1, 1, 50);
    repeat (20) step();
    chk("early.start_pulses", 32'(ts_cnt[1]), 32'd1);
    chk("early.rts_clocks", 32'(rts_cnt[1]), 32'd6);
    chk("early.rts_idle", 32'(rt[1]), 32'd0);
    early[1] = 1'b0; blen[1] = 4;
    pend[1][0] = 1'b1; pdat[1][0] = 8'hC3;
    run_until_sent(1, 2, 50);
    chk("early.next_data", 32'(sdat[1][1]), 32'hC3);
    drain(1);

    // reset asserted while waiting for the frame to finish
    blen[0] = 30;
    pend[0][0] = 1'b1; pdat[0][0] = 8'h77;
    begin
      int hi = 0;
      int b = 0;
      while (hi < 3 && b < 100) begin
        step(); b++;
        if (bsy[0]) hi++;
      end
      chk("midrst.reached_wait_done", 32'(hi), 32'd3);
    end
    rst_cmd = 1'b1;
    step();
    chk("midrst.rts", 32'(rt[0]), 32'd0);
    chk("midrst.tx_data", 32'(td[0]), 32'd0);
    chk("midrst.grant_id", 32'(gi[0]), 32'd0);
    rst_cmd = 1'b0;
    pend[0][1] = 1'b1; pdat[0][1] = 8'h99;
    step();
    chk("midrst.reaccept", 32'(r1[0]), 32'd1);
    blen[0] = 4;
    drain(0);

    // random traffic on both instances
    rnd = 1'b1;
    clear_log(0); clear_log(1);
    repeat (3000) step();
    rnd = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 2; r++) begin
        pend[i][r] = 1'b0; cont[i][r] = 0;
      end
    drain(0);
    drain(1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
